// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// threshold flags, write-when-full-with-read, flush and sticky error flags.
module fifo_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 6,
   parameter int FWFT      = 0,
   parameter int AFULL_TH  = 56,
   parameter int AEMPTY_TH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              overflow_r;
   logic              underflow_r;
   logic              empty_s;
   logic              full_s;
   logic              rd_ok_s;
   logic              wr_ok_s;
   logic              rd_acc_s;
   logic              wr_acc_s;
   logic              ovf_set_s;
   logic              udf_set_s;

   // Status decode from the count register and request acceptance; flush masks everything.
   always_comb begin
      empty_s   = (count_r == {(ADDR_W+1){1'b0}});
      full_s    = (count_r == (ADDR_W+1)'(DEPTH));
      rd_ok_s   = rd_en & ~empty_s;
      wr_ok_s   = wr_en & (~full_s | rd_en);
      rd_acc_s  = rd_ok_s & ~flush;
      wr_acc_s  = wr_ok_s & ~flush;
      ovf_set_s = wr_en & ~wr_ok_s & ~flush;
      udf_set_s = rd_en & empty_s & ~flush;
   end

   assign empty        = empty_s;
   assign full         = full_s;
   assign almost_empty = (count_r <= (ADDR_W+1)'(AEMPTY_TH));
   assign almost_full  = (count_r >= (ADDR_W+1)'(AFULL_TH));
   assign count        = count_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {ADDR_W{1'b0}};
         rd_ptr_r <= {ADDR_W{1'b0}};
         count_r  <= {(ADDR_W+1){1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {ADDR_W{1'b0}};
         rd_ptr_r <= {ADDR_W{1'b0}};
         count_r  <= {(ADDR_W+1){1'b0}};
      end else begin
         if (wr_acc_s) wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
         if (rd_acc_s) rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_r <= count_r + (ADDR_W+1)'(1);
            2'b01:   count_r <= count_r - (ADDR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array, deliberately without reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) mem_r[wr_ptr_r] <= din;
   end

   // Sticky error flags: a new error wins over a same-cycle clear; flush leaves them alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (ovf_set_s)    overflow_r <= 1'b1;
         else if (clr_err) overflow_r <= 1'b0;
         if (udf_set_s)    underflow_r <= 1'b1;
         else if (clr_err) underflow_r <= 1'b0;
      end
   end

   generate
      if (FWFT == 0) begin : g_std
         logic [DATA_W-1:0] dout_r;
         logic              dout_valid_r;

         // Registered read port with one-cycle latency.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dout_r       <= {DATA_W{1'b0}};
               dout_valid_r <= 1'b0;
            end else if (flush) begin
               dout_r       <= {DATA_W{1'b0}};
               dout_valid_r <= 1'b0;
            end else if (rd_acc_s) begin
               dout_r       <= mem_r[rd_ptr_r];
               dout_valid_r <= 1'b1;
            end else begin
               dout_valid_r <= 1'b0;
            end
         end

         assign dout       = dout_r;
         assign dout_valid = dout_valid_r;
      end else begin : g_fwft
         // Head word is presented directly from storage; rd_en acknowledges it.
         always_comb begin
            if (empty_s) begin
               dout = {DATA_W{1'b0}};
            end else begin
               dout = mem_r[rd_ptr_r];
            end
            dout_valid = ~empty_s;
         end
      end
   endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a standard-mode and an FWFT-mode instance,
// both DEPTH=4, AFULL_TH=3, AEMPTY_TH=1.
module tb_fifo_param;

   localparam int DW = 8;
   localparam int AW = 2;
   localparam int AF = 3;
   localparam int AE = 1;

   if (AF < 1 || AF > (2 ** AW) || AE < 0 || AE > (2 ** AW) - 1) begin : g_cfg_bad
      $error("fifo_param threshold parameters out of legal range");
   end

   logic          clk = 1'b0;
   logic          rst;
   logic          a_flush, a_wr, a_rd, a_clr;
   logic [DW-1:0] a_din, a_dout;
   logic          a_dv, a_empty, a_full, a_ae, a_af, a_ov, a_un;
   logic [AW:0]   a_count;
   logic          b_flush, b_wr, b_rd, b_clr;
   logic [DW-1:0] b_din, b_dout;
   logic          b_dv, b_empty, b_full, b_ae, b_af, b_ov, b_un;
   logic [AW:0]   b_count;

   int checks = 0;
   int errors = 0;

   fifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_std (
      .clk(clk), .rst(rst), .flush(a_flush), .wr_en(a_wr), .din(a_din), .rd_en(a_rd),
      .dout(a_dout), .dout_valid(a_dv), .empty(a_empty), .full(a_full),
      .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
      .overflow(a_ov), .underflow(a_un), .clr_err(a_clr));

   fifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_fwft (
      .clk(clk), .rst(rst), .flush(b_flush), .wr_en(b_wr), .din(b_din), .rd_en(b_rd),
      .dout(b_dout), .dout_valid(b_dv), .empty(b_empty), .full(b_full),
      .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
      .overflow(b_ov), .underflow(b_un), .clr_err(b_clr));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({a_count, a_empty, a_ae, a_af, a_full, a_ov, a_un, a_dv} !== 10'b000_1100_000) begin
         errors++;
         $display("FAIL reset_std_flags got %b want %b",
                  {a_count, a_empty, a_ae, a_af, a_full, a_ov, a_un, a_dv}, 10'b000_1100_000);
      end
      checks++;
      if (a_dout !== 8'h00) begin
         errors++; $display("FAIL reset_std_dout got %h want 00", a_dout);
      end
      checks++;
      if ({b_count, b_empty, b_dv, b_dout} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_fwft got count=%0d empty=%b dv=%b dout=%h", b_count, b_empty, b_dv, b_dout);
      end
   endtask

   task automatic test_fill();
      logic [DW-1:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [6:0]    ef [4] = '{7'b001_0100, 7'b010_0000, 7'b011_0010, 7'b100_0011};
      for (int i = 0; i < 4; i++) begin
         a_wr = 1'b1; a_din = d[i];
         tick();
         checks++;
         if ({a_count, a_empty, a_ae, a_af, a_full} !== ef[i]) begin
            errors++;
            $display("FAIL fill_flags[%0d] got %b want %b", i, {a_count, a_empty, a_ae, a_af, a_full}, ef[i]);
         end
      end
      a_din = 8'h55;
      tick();
      a_wr = 1'b0;
      checks++;
      if ({a_count, a_full, a_ov} !== {3'd4, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL fill_overflow got count=%0d full=%b ov=%b want 4 1 1", a_count, a_full, a_ov);
      end
   endtask

   task automatic test_std_read();
      logic [DW-1:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      a_rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({a_dout, a_dv, a_count} !== {d[i], 1'b1, 3'(3 - i)}) begin
            errors++;
            $display("FAIL std_read[%0d] got dout=%h dv=%b count=%0d want %h 1 %0d",
                     i, a_dout, a_dv, a_count, d[i], 3 - i);
         end
      end
      checks++;
      if (a_empty !== 1'b1) begin
         errors++; $display("FAIL std_read_empty got %b want 1", a_empty);
      end
      tick();
      a_rd = 1'b0;
      checks++;
      if ({a_un, a_dout, a_dv} !== {1'b1, 8'h44, 1'b0}) begin
         errors++;
         $display("FAIL std_underflow got un=%b dout=%h dv=%b want 1 44 0", a_un, a_dout, a_dv);
      end
   endtask

   task automatic test_write_full_read();
      logic [DW-1:0] d [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
      logic [DW-1:0] q [4] = '{8'hB2, 8'hB3, 8'hB4, 8'h66};
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      checks++;
      if ({a_ov, a_un} !== 2'b00) begin
         errors++; $display("FAIL clr_err got ov=%b un=%b want 0 0", a_ov, a_un);
      end
      a_wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_din = d[i];
         tick();
      end
      a_din = 8'h66; a_rd = 1'b1;
      tick();
      a_wr = 1'b0;
      checks++;
      if ({a_count, a_full, a_ov, a_dout, a_dv} !== {3'd4, 1'b1, 1'b0, 8'hB1, 1'b1}) begin
         errors++;
         $display("FAIL wr_full_rd got count=%0d full=%b ov=%b dout=%h dv=%b want 4 1 0 b1 1",
                  a_count, a_full, a_ov, a_dout, a_dv);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (a_dout !== q[i]) begin
            errors++; $display("FAIL wr_full_drain[%0d] got %h want %h", i, a_dout, q[i]);
         end
      end
      a_rd = 1'b0;
      a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h77;
      tick();
      a_wr = 1'b0; a_rd = 1'b0;
      checks++;
      if ({a_count, a_un, a_dv} !== {3'd1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL empty_wr_rd got count=%0d un=%b dv=%b want 1 1 0", a_count, a_un, a_dv);
      end
      a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      checks++;
      if ({a_dout, a_count} !== {8'h77, 3'd0}) begin
         errors++; $display("FAIL empty_wr_rd_out got dout=%h count=%0d want 77 0", a_dout, a_count);
      end
   endtask

   task automatic test_fwft();
      b_wr = 1'b1; b_din = 8'hA5;
      tick();
      b_wr = 1'b0;
      checks++;
      if ({b_dout, b_dv, b_count} !== {8'hA5, 1'b1, 3'd1}) begin
         errors++;
         $display("FAIL fwft_write got dout=%h dv=%b count=%0d want a5 1 1", b_dout, b_dv, b_count);
      end
      b_rd = 1'b1;
      tick();
      b_rd = 1'b0;
      checks++;
      if ({b_dout, b_dv, b_empty} !== {8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL fwft_pop got dout=%h dv=%b empty=%b want 00 0 1", b_dout, b_dv, b_empty);
      end
      b_wr = 1'b1; b_din = 8'h5A;
      tick();
      b_din = 8'hC3;
      tick();
      b_wr = 1'b0;
      checks++;
      if (b_dout !== 8'h5A) begin
         errors++; $display("FAIL fwft_head got %h want 5a", b_dout);
      end
      b_rd = 1'b1;
      tick();
      b_rd = 1'b0;
      checks++;
      if ({b_dout, b_count} !== {8'hC3, 3'd1}) begin
         errors++; $display("FAIL fwft_next got dout=%h count=%0d want c3 1", b_dout, b_count);
      end
   endtask

   task automatic test_wrap_flush();
      for (int i = 1; i <= 6; i++) begin
         a_wr = 1'b1; a_din = 8'(i);
         tick();
         a_wr = 1'b0; a_rd = 1'b1;
         tick();
         a_rd = 1'b0;
         checks++;
         if ({a_dout, a_dv, a_count} !== {8'(i), 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL wrap[%0d] got dout=%h dv=%b count=%0d want %h 1 0", i, a_dout, a_dv, a_count, 8'(i));
         end
      end
      a_wr = 1'b1; a_din = 8'hC1;
      tick();
      a_din = 8'hC2;
      tick();
      a_wr = 1'b0;
      a_flush = 1'b1; a_wr = 1'b1; a_rd = 1'b1; a_din = 8'hEE;
      tick();
      a_flush = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
      checks++;
      if ({a_count, a_empty, a_ae, a_af, a_full, a_dout, a_dv, a_ov, a_un}
          !== {3'd0, 4'b1100, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL flush got count=%0d empty=%b dout=%h dv=%b ov=%b un=%b want 0 1 00 0 0 1",
                  a_count, a_empty, a_dout, a_dv, a_ov, a_un);
      end
      a_clr = 1'b1; a_rd = 1'b1;
      tick();
      a_clr = 1'b0; a_rd = 1'b0;
      checks++;
      if (a_un !== 1'b1) begin
         errors++; $display("FAIL set_over_clear got un=%b want 1", a_un);
      end
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      checks++;
      if ({a_ov, a_un} !== 2'b00) begin
         errors++; $display("FAIL clr_after_flush got ov=%b un=%b want 0 0", a_ov, a_un);
      end
   endtask

   task automatic test_async_reset();
      logic [DW-1:0] d [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      a_wr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a_din = d[i];
         tick();
      end
      a_wr = 1'b0; a_rd = 1'b1;
      tick();
      tick();
      a_rd = 1'b0;
      a_wr = 1'b1; a_din = 8'h36;
      tick();
      a_wr = 1'b0;
      checks++;
      if ({a_count, a_ov, a_dout} !== {3'd3, 1'b1, 8'h32}) begin
         errors++;
         $display("FAIL pre_reset got count=%0d ov=%b dout=%h want 3 1 32", a_count, a_ov, a_dout);
      end
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({a_count, a_empty, a_ae, a_af, a_full, a_ov, a_un, a_dv, a_dout}
          !== {3'd0, 4'b1100, 3'b000, 8'h00}) begin
         errors++;
         $display("FAIL async_reset got count=%0d empty=%b ov=%b dv=%b dout=%h want 0 1 0 0 00",
                  a_count, a_empty, a_ov, a_dv, a_dout);
      end
      @(negedge clk);
      rst = 1'b0;
      a_wr = 1'b1; a_din = 8'h7E;
      tick();
      a_wr = 1'b0; a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      checks++;
      if ({a_dout, a_dv, a_count} !== {8'h7E, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL post_reset_rw got dout=%h dv=%b count=%0d want 7e 1 0", a_dout, a_dv, a_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_flush = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_din = 8'h00;
      b_flush = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = 8'h00;
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_fill();
      test_std_read();
      test_write_full_read();
      test_fwft();
      test_wrap_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous single-clock FIFO, successor to the fixed 64x8 UART byte buffer. Data width and depth are configurable. Adds a selectable first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, write-when-full-with-read, synchronous flush and sticky overflow/underflow flags. Sits between the UART RX/TX engines and the host-side logic; one instance per direction.

Parameters:
DATA_W, 8, width of each stored word in bits.
ADDR_W, 6, pointer width; DEPTH = 2**ADDR_W words (64 by default).
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word fall-through.
AFULL_TH, 56, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
AEMPTY_TH, 8, almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
flush  in  1  synchronous clear of contents, pointers and count.
wr_en  in  1  write request.
din  in  DATA_W  write data.
rd_en  in  1  read request (standard mode) or head acknowledge (FWFT mode).
dout  out  DATA_W  read data.
dout_valid  out  1  dout holds a freshly read word.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
almost_empty  out  1  count <= AEMPTY_TH.
almost_full  out  1  count >= AFULL_TH.
count  out  ADDR_W+1  words currently stored, 0..DEPTH.
overflow  out  1  sticky: a write was rejected.
underflow  out  1  sticky: a read was rejected.
clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async): wr_ptr, rd_ptr and count go to 0; dout = 0; dout_valid = 0; overflow = underflow = 0; empty = 1; full = 0; almost_empty = 1; almost_full = 0 (AFULL_TH >= 1). Memory array is not reset.
- rd_acc = rd_en & ~empty. A read of an empty FIFO is never accepted, even when a write occurs in the same cycle.
- wr_acc = wr_en & (~full | rd_en). When full, a write is accepted only together with a same-cycle read.
- Accepted write: mem[wr_ptr] <= din; wr_ptr increments. Accepted read: rd_ptr increments. Both pointers wrap DEPTH-1 -> 0 by natural overflow.
- count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
- empty, full, almost_empty and almost_full are decoded combinationally from the count register, so they reflect state after the last clock edge.
- FWFT = 0 (standard mode):
  - dout is registered; on rd_acc, dout <= mem[rd_ptr], visible on the next cycle (1-cycle latency).
  - dout_valid = 1 for exactly the cycle after each rd_acc, otherwise 0.
  - dout holds its last value when there is no read.
- FWFT = 1 (first-word fall-through mode):
  - dout = mem[rd_ptr] when ~empty, and 0 when empty.
  - dout_valid = ~empty.
  - rd_en pops the head. The next word, or 0 if the FIFO becomes empty, appears the cycle after the pop.
  - A word written into an empty FIFO appears on dout the cycle after the write.
- Errors:
  - overflow sets on wr_en & ~wr_acc.
  - underflow sets on rd_en & empty.
  - Both are cleared by clr_err; a set condition in the same cycle takes priority over clear.
  - Errors are unaffected by flush.
- flush:
  - Next edge: pointers and count go to 0. In standard mode, dout and dout_valid also go to 0.
  - Same-cycle wr_en and rd_en are ignored and raise no error flags.
  - Memory contents are left stale.
- rst asserted mid-operation: immediate return to reset values; the first write after deassertion lands at address 0.
- Out-of-range thresholds are illegal configurations; the bench must check them with an elaboration-time assertion.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=2 (DEPTH=4), AFULL_TH=3, AEMPTY_TH=1.
1. Reset, then write 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> count 1,2,3,4; almost_empty drops at count 2; almost_full rises at count 3; full=1 at count 4; a 5th write of 0x55 is rejected, count stays 4, overflow=1.
2. Standard mode, full FIFO from scenario 1, rd_en held 4 cycles -> dout 0x11,0x22,0x33,0x44 each one cycle after its read, dout_valid high 4 cycles; empty=1 after; a 5th rd_en sets underflow=1 and leaves dout=0x44.
3. Full FIFO, wr_en=1 with din=0x66 and rd_en=1 in the same cycle -> write accepted, count stays 4, no overflow; after draining, 0x66 is the last word out. Also: empty FIFO with wr_en and rd_en together -> count becomes 1, underflow=1.
4. FWFT=1: write 0xA5 into empty FIFO -> next cycle dout=0xA5, dout_valid=1; pulse rd_en -> next cycle dout=0, dout_valid=0, empty=1.
5. Wrap-around: 6 alternating write/read pairs of 0x01..0x06 -> pointers wrap past 3 with data order preserved; then flush with 2 words stored -> count=0, empty=1; overflow/underflow unchanged until a clr_err pulse clears them.
6. Assert rst asynchronously (mid-clock) with 3 words stored -> all outputs at reset values immediately; after deassertion, write 0x7E and read it back -> dout=0x7E.
